// File: rtl/lfsr_pkg.sv
// PRBS polynomial tap masks (bit k-1 set = tap at x^k) and checker FSM state type.
package lfsr_pkg;

    localparam logic [31:0] PRBS7  = 32'h0000_0060;  // x^7  + x^6  + 1
    localparam logic [31:0] PRBS15 = 32'h0000_6000;  // x^15 + x^14 + 1
    localparam logic [31:0] PRBS23 = 32'h0042_0000;  // x^23 + x^18 + 1
    localparam logic [31:0] PRBS31 = 32'h4800_0000;  // x^31 + x^28 + 1

    typedef enum logic {
        SEARCH,
        LOCKED
    } prbs_chk_state_e;

endpackage

// File: rtl/prbs_expect.sv
// Unrolled one-beat PRBS predictor: predicted word, per-bit error mask and next history.
module prbs_expect #(
    parameter int unsigned              POLY_DEGREE = 7,
    parameter logic [POLY_DEGREE-1:0]   POLYNOMIAL  = 7'h60,
    parameter int unsigned              TDATA_WIDTH = 8
) (
    input  logic [POLY_DEGREE-1:0] hist_i,
    input  logic [TDATA_WIDTH-1:0] rx_i,
    input  logic                   free_run_i,
    output logic [TDATA_WIDTH-1:0] pred_o,
    output logic [TDATA_WIDTH-1:0] err_o,
    output logic [POLY_DEGREE-1:0] hist_o
);

    logic [POLY_DEGREE-1:0] h;
    logic                   nb;

    // Self-sync shifts in received bits; free-run shifts in predictions so errors do not propagate.
    always_comb begin
        h      = hist_i;
        nb     = 1'b0;
        pred_o = '0;
        err_o  = '0;
        for (int unsigned i = 0; i < TDATA_WIDTH; i++) begin
            pred_o[i] = ^(h & POLYNOMIAL);
            err_o[i]  = pred_o[i] ^ rx_i[i];
            nb        = free_run_i ? pred_o[i] : rx_i[i];
            h         = {h[POLY_DEGREE-2:0], nb};
        end
        hist_o = h;
    end

endmodule

// File: rtl/axi4s_prbs_checker.sv
// AXI4-Stream PRBS sink: self-synchronises in SEARCH, counts bit errors against the
// free-running prediction in LOCKED, and reports lock/error status.
module axi4s_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned            POLY_DEGREE  = 7,
    parameter logic [POLY_DEGREE-1:0] POLYNOMIAL   = PRBS7[POLY_DEGREE-1:0],
    parameter logic [POLY_DEGREE-1:0] SEED         = 1,
    parameter int unsigned            TDATA_WIDTH  = 8,
    parameter int unsigned            LOCK_COUNT   = 16,
    parameter int unsigned            UNLOCK_COUNT = 4,
    parameter bit                     TLAST_RESEED = 1'b1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   target_tvalid,
    output logic                   target_tready,
    input  logic [TDATA_WIDTH-1:0] target_tdata,
    input  logic                   target_tlast,
    input  logic                   clear,
    output logic                   locked,
    output logic                   beat_error,
    output logic [31:0]            bit_errors,
    output logic [15:0]            lock_losses
);

    localparam int unsigned CLEAN_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W   = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned CNT_W   = $clog2(TDATA_WIDTH + 1);

    prbs_chk_state_e        state_q, state_d;
    logic [POLY_DEGREE-1:0] hist_q, hist_d, hist_next;
    logic [CLEAN_W-1:0]     clean_cnt_q, clean_cnt_d;
    logic [BAD_W-1:0]       bad_cnt_q, bad_cnt_d;
    logic                   tready_q;
    logic                   beat_error_q, beat_error_d;
    logic [31:0]            bit_errors_q, bit_errors_d;
    logic [15:0]            lock_losses_q, lock_losses_d;
    logic [TDATA_WIDTH-1:0] pred, err_mask;
    logic [CNT_W-1:0]       popcnt;
    logic [32:0]            err_sum;
    logic                   accept, dirty, lock_hit, unlock_hit;

    prbs_expect #(
        .POLY_DEGREE (POLY_DEGREE),
        .POLYNOMIAL  (POLYNOMIAL),
        .TDATA_WIDTH (TDATA_WIDTH)
    ) u_expect (
        .hist_i     (hist_q),
        .rx_i       (target_tdata),
        .free_run_i (state_q == LOCKED),
        .pred_o     (pred),
        .err_o      (err_mask),
        .hist_o     (hist_next)
    );

    assign accept     = target_tvalid && tready_q;
    assign dirty      = |err_mask;
    assign lock_hit   = !dirty && (clean_cnt_q == CLEAN_W'(LOCK_COUNT - 1));
    assign unlock_hit = dirty && (bad_cnt_q == BAD_W'(UNLOCK_COUNT - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= SEARCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                SEARCH:  if (lock_hit)   state_d = LOCKED;
                LOCKED:  if (unlock_hit) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    always_comb begin
        popcnt = '0;
        for (int unsigned i = 0; i < TDATA_WIDTH; i++) begin
            popcnt = popcnt + CNT_W'(err_mask[i]);
        end
        err_sum = {1'b0, bit_errors_q} + 33'(popcnt);
    end

    always_comb begin
        hist_d        = hist_q;
        clean_cnt_d   = clean_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        beat_error_d  = 1'b0;
        bit_errors_d  = bit_errors_q;
        lock_losses_d = lock_losses_q;
        if (accept) begin
            hist_d = (TLAST_RESEED && target_tlast) ? SEED : hist_next;
            if (state_q == SEARCH) begin
                bad_cnt_d   = '0;
                clean_cnt_d = (dirty || lock_hit) ? '0 : clean_cnt_q + CLEAN_W'(1);
            end else begin
                clean_cnt_d  = '0;
                bad_cnt_d    = (!dirty || unlock_hit) ? '0 : bad_cnt_q + BAD_W'(1);
                beat_error_d = dirty;
                bit_errors_d = err_sum[32] ? '1 : err_sum[31:0];
                if (unlock_hit && (lock_losses_q != '1)) lock_losses_d = lock_losses_q + 16'd1;
            end
        end
        if (clear) bit_errors_d = '0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tready_q      <= 1'b0;
            hist_q        <= SEED;
            clean_cnt_q   <= '0;
            bad_cnt_q     <= '0;
            beat_error_q  <= 1'b0;
            bit_errors_q  <= '0;
            lock_losses_q <= '0;
        end else begin
            tready_q      <= 1'b1;
            hist_q        <= hist_d;
            clean_cnt_q   <= clean_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            beat_error_q  <= beat_error_d;
            bit_errors_q  <= bit_errors_d;
            lock_losses_q <= lock_losses_d;
        end
    end

    assign target_tready = tready_q;
    assign beat_error    = beat_error_q;
    assign bit_errors    = bit_errors_q;
    assign lock_losses   = lock_losses_q;

endmodule
